// File: rtl/rtc_calendar.sv
// rtl/rtc_calendar.sv - RTC seconds count to calendar fields converter
module rtc_calendar #(
   parameter int EPOCH_YEAR = 1970,
   parameter int EPOCH_DOW  = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] cnt_i,
   output logic        ready_o,
   output logic        valid_o,
   output logic [5:0]  sec_o,
   output logic [5:0]  min_o,
   output logic [4:0]  hour_o,
   output logic [4:0]  day_o,
   output logic [3:0]  mon_o,
   output logic [11:0] year_o,
   output logic [2:0]  dow_o
);

   localparam logic [11:0] EPOCH_YEAR_L = 12'(EPOCH_YEAR);
   localparam logic [15:0] EPOCH_DOW_L  = 16'(EPOCH_DOW);

   typedef enum logic [2:0] {
      IDLE, DIV_DAY, DIV_HR, DIV_MIN, DIV_DOW, YEAR, MONTH, DONE
   } state_t;

   state_t state_q, state_d;

   // shared restoring divider: dividend is left-aligned in dvd_q, one quotient bit per cycle
   logic [31:0] dvd_q;
   logic [16:0] rem_q;
   logic [31:0] quo_q;
   logic [16:0] divisor_q;
   logic [4:0]  div_cnt_q;

   // working fields, copied to the outputs only when the month walk finishes
   logic [15:0] days_q;
   logic [4:0]  hour_q;
   logic [5:0]  min_q;
   logic [5:0]  sec_q;
   logic [2:0]  dow_q;
   logic [11:0] yr_q;
   logic [15:0] rd_q;
   logic [3:0]  mon_q;

   logic [17:0] trial;
   logic        ge;
   logic [16:0] rem_step;
   logic [31:0] quo_step;
   logic        div_last;
   logic [8:0]  ylen;
   logic [4:0]  mlen;
   logic        year_adv;
   logic        mon_adv;

   function automatic logic is_leap(input logic [11:0] y);
      is_leap = (y[1:0] == 2'b00) &&
                !(((y % 12'd100) == 12'd0) && ((y % 12'd400) != 12'd0));
   endfunction

   function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
      case (m)
         4'd2:                      month_len = leap ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:   month_len = 5'd30;
         default:                   month_len = 5'd31;
      endcase
   endfunction

   // one divider step plus the year/month walk comparisons
   always_comb begin
      trial    = {rem_q, dvd_q[31]};
      ge       = trial >= {1'b0, divisor_q};
      rem_step = ge ? 17'(trial - {1'b0, divisor_q}) : trial[16:0];
      quo_step = {quo_q[30:0], ge};
      div_last = (div_cnt_q == 5'd0);
      ylen     = is_leap(yr_q) ? 9'd366 : 9'd365;
      mlen     = month_len(mon_q, is_leap(yr_q));
      year_adv = rd_q >= {7'd0, ylen};
      mon_adv  = rd_q >= {11'd0, mlen};
   end

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next-state logic and handshake outputs
   always_comb begin
      state_d = state_q;
      ready_o = (state_q == IDLE);
      valid_o = (state_q == DONE);
      case (state_q)
         IDLE:    if (start_i)  state_d = DIV_DAY;
         DIV_DAY: if (div_last) state_d = DIV_HR;
         DIV_HR:  if (div_last) state_d = DIV_MIN;
         DIV_MIN: if (div_last) state_d = DIV_DOW;
         DIV_DOW: if (div_last) state_d = YEAR;
         YEAR:    if (!year_adv) state_d = MONTH;
         MONTH:   if (!mon_adv)  state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // datapath: divider phases chain their operands, then year and month walks
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dvd_q <= '0; rem_q <= '0; quo_q <= '0; divisor_q <= '0; div_cnt_q <= '0;
         days_q <= '0; hour_q <= '0; min_q <= '0; sec_q <= '0; dow_q <= '0;
         yr_q <= '0; rd_q <= '0; mon_q <= '0;
         sec_o <= '0; min_o <= '0; hour_o <= '0; day_o <= '0;
         mon_o <= '0; year_o <= '0; dow_o <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  dvd_q     <= cnt_i;
                  rem_q     <= '0;
                  quo_q     <= '0;
                  divisor_q <= 17'd86400;
                  div_cnt_q <= 5'd31;
               end
            end
            DIV_DAY, DIV_HR, DIV_MIN, DIV_DOW: begin
               dvd_q     <= {dvd_q[30:0], 1'b0};
               rem_q     <= rem_step;
               quo_q     <= quo_step;
               div_cnt_q <= div_cnt_q - 5'd1;
               if (div_last) begin
                  rem_q <= '0;
                  quo_q <= '0;
                  case (state_q)
                     DIV_DAY: begin
                        days_q    <= quo_step[15:0];
                        dvd_q     <= {rem_step, 15'd0};
                        divisor_q <= 17'd3600;
                        div_cnt_q <= 5'd16;
                     end
                     DIV_HR: begin
                        hour_q    <= quo_step[4:0];
                        dvd_q     <= {rem_step[11:0], 20'd0};
                        divisor_q <= 17'd60;
                        div_cnt_q <= 5'd11;
                     end
                     DIV_MIN: begin
                        min_q     <= quo_step[5:0];
                        sec_q     <= rem_step[5:0];
                        dvd_q     <= {days_q + EPOCH_DOW_L, 16'd0};
                        divisor_q <= 17'd7;
                        div_cnt_q <= 5'd15;
                     end
                     default: begin
                        dow_q <= rem_step[2:0];
                        yr_q  <= EPOCH_YEAR_L;
                        rd_q  <= days_q;
                        mon_q <= 4'd1;
                     end
                  endcase
               end
            end
            YEAR: begin
               if (year_adv) begin
                  rd_q <= rd_q - {7'd0, ylen};
                  yr_q <= yr_q + 12'd1;
               end
            end
            MONTH: begin
               if (mon_adv) begin
                  rd_q  <= rd_q - {11'd0, mlen};
                  mon_q <= mon_q + 4'd1;
               end else begin
                  sec_o  <= sec_q;
                  min_o  <= min_q;
                  hour_o <= hour_q;
                  day_o  <= 5'(rd_q + 16'd1);
                  mon_o  <= mon_q;
                  year_o <= yr_q;
                  dow_o  <= dow_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rtc_calendar.sv
// tb/tb_rtc_calendar.sv - directed self-checking bench for rtc_calendar
module tb_rtc_calendar;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] cnt_i = '0;
   logic        ready_o, valid_o;
   logic [5:0]  sec_o, min_o;
   logic [4:0]  hour_o, day_o;
   logic [3:0]  mon_o;
   logic [11:0] year_o;
   logic [2:0]  dow_o;

   int total = 0;
   int bad   = 0;
   int lat;
   int extra;

   rtc_calendar #(.EPOCH_YEAR(1970), .EPOCH_DOW(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cnt_i(cnt_i),
      .ready_o(ready_o), .valid_o(valid_o),
      .sec_o(sec_o), .min_o(min_o), .hour_o(hour_o), .day_o(day_o),
      .mon_o(mon_o), .year_o(year_o), .dow_o(dow_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [63:0] pack(input int y, input int mo, input int d,
                                        input int h, input int mi, input int s, input int w);
      pack = {23'd0, 12'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s), 3'(w)};
   endfunction

   function automatic logic [63:0] fields();
      fields = {23'd0, year_o, mon_o, day_o, hour_o, min_o, sec_o, dow_o};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // accept on the next edge, then count cycles (first cycle after accept = 1) until valid_o
   task automatic run(input logic [31:0] c, input int pulse_at, output int n);
      @(negedge clk_i);
      start_i = 1'b1;
      cnt_i   = c;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
         if (n == 1) start_i = 1'b0;
         if (pulse_at != 0 && n == pulse_at)     begin start_i = 1'b1; cnt_i = 32'd0; end
         if (pulse_at != 0 && n == pulse_at + 1) start_i = 1'b0;
      end while (!valid_o && n < 400);
      if (n >= 400) begin
         total++; bad++;
         $display("FAIL timeout observed=no_valid expected=valid");
      end
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      chk("reset_ready", 64'(ready_o), 64'd1);
      chk("reset_valid", 64'(valid_o), 64'd0);
      chk("reset_fields", fields(), 64'd0);

      run(32'd0, 0, lat);
      chk("t1_fields", fields(), pack(1970, 1, 1, 0, 0, 0, 4));
      chk("t1_latency", 64'(lat), 64'd80);
      @(negedge clk_i);
      chk("t1_ready_after", 64'(ready_o), 64'd1);
      chk("t1_valid_drop", 64'(valid_o), 64'd0);
      chk("t1_hold", fields(), pack(1970, 1, 1, 0, 0, 0, 4));

      run(32'd951782400, 0, lat);
      chk("t2_fields", fields(), pack(2000, 2, 29, 0, 0, 0, 2));
      chk("t2_latency", 64'(lat), 64'd111);

      run(32'd4107542399, 0, lat);
      chk("t3a_fields", fields(), pack(2100, 2, 28, 23, 59, 59, 0));
      chk("t3a_latency", 64'(lat), 64'd211);
      run(32'd4107542400, 0, lat);
      chk("t3b_fields", fields(), pack(2100, 3, 1, 0, 0, 0, 1));
      chk("t3b_latency", 64'(lat), 64'd212);

      run(32'hFFFFFFFF, 0, lat);
      chk("t4_fields", fields(), pack(2106, 2, 7, 6, 28, 15, 0));
      chk("t4_latency", 64'(lat), 64'd217);

      run(32'd1234567890, 30, lat);
      chk("t5_fields", fields(), pack(2009, 2, 13, 23, 31, 30, 5));
      chk("t5_latency", 64'(lat), 64'd120);
      extra = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_i);
         if (valid_o) extra++;
      end
      chk("t5_extra_valid", 64'(extra), 64'd0);
      chk("t5_hold", fields(), pack(2009, 2, 13, 23, 31, 30, 5));

      @(negedge clk_i);
      start_i = 1'b1;
      cnt_i   = 32'd1234567890;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (39) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("t6_ready", 64'(ready_o), 64'd1);
      chk("t6_valid", 64'(valid_o), 64'd0);
      chk("t6_fields", fields(), 64'd0);
      extra = 0;
      for (int i = 0; i < 250; i++) begin
         @(negedge clk_i);
         if (valid_o) extra++;
      end
      chk("t6_no_valid", 64'(extra), 64'd0);
      run(32'd90061, 0, lat);
      chk("t6_new_fields", fields(), pack(1970, 1, 2, 1, 1, 1, 5));
      chk("t6_new_latency", 64'(lat), 64'd80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
